// File: rtl/design_mux_pkg.sv
// design_mux_pkg: shared IDs, default population mask and sequencer states for the pad mux.
package design_mux_pkg;
  localparam int DESIGN_ID_W = 4;
  localparam logic [DESIGN_ID_W-1:0] ID_RAYBOX_FSM   = 4'd0;
  localparam logic [DESIGN_ID_W-1:0] ID_TEST_PATTERN = 4'd15;
  localparam logic [15:0] DEFAULT_VALID_MASK = 16'h8001;
  typedef enum logic [1:0] {IDLE, QUIESCE, HOLD_RST, ACK} state_t;
endpackage

// File: rtl/sync2.sv
// sync2: two-flop synchroniser for a single asynchronous level.
module sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic m;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, m} <= 2'b00;
    else {q, m} <= {m, d};
endmodule

// File: rtl/design_select_ctrl.sv
// design_select_ctrl: sequences a safe switch of the pad-mux design ID requested over a req/ack handshake.
module design_select_ctrl
  import design_mux_pkg::*;
#(
  parameter int QUIESCE_CYCLES = 16,
  parameter int RST_CYCLES = 8,
  parameter logic [15:0] VALID_MASK = DEFAULT_VALID_MASK,
  parameter logic [DESIGN_ID_W-1:0] DEFAULT_ID = ID_TEST_PATTERN,
  parameter int CNT_W = 8
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_n,
  input  logic                   req_i,
  input  logic [DESIGN_ID_W-1:0] req_id_i,
  output logic                   ack_o,
  output logic                   err_o,
  output logic                   busy_o,
  output logic [DESIGN_ID_W-1:0] sel_id_o,
  output logic                   safe_o,
  output logic [15:0]            design_rst_n_o
);
  localparam logic [CNT_W-1:0] Q_LOAD = CNT_W'(QUIESCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] R_LOAD = CNT_W'(RST_CYCLES - 1);
  // boot spends one cycle in IDLE, so its hold count is one shorter
  localparam logic [CNT_W-1:0] B_LOAD = CNT_W'(RST_CYCLES > 1 ? RST_CYCLES - 2 : 0);
  state_t state;
  logic [CNT_W-1:0] cnt;
  logic [DESIGN_ID_W-1:0] id_q;
  logic req_s, req_q, boot;
  sync2 u_sync (.clk(wb_clk_i), .rst_n(wb_rst_n), .d(req_i), .q(req_s));
  assign busy_o = state != IDLE;
  always_ff @(posedge wb_clk_i or negedge wb_rst_n)
    if (!wb_rst_n) begin
      state <= IDLE;
      cnt <= '0;
      id_q <= DEFAULT_ID;
      sel_id_o <= DEFAULT_ID;
      safe_o <= 1'b0;
      ack_o <= 1'b0;
      err_o <= 1'b0;
      design_rst_n_o <= ~(16'd1 << DEFAULT_ID);
      boot <= 1'b1;
      req_q <= 1'b0;
    end else begin
      req_q <= req_s;
      case (state)
        IDLE:
          if (boot) begin
            cnt <= B_LOAD;
            state <= HOLD_RST;
          end else if (req_s && !req_q) begin
            if (!VALID_MASK[req_id_i]) begin
              err_o <= 1'b1;
              ack_o <= 1'b1;
              state <= ACK;
            end else begin
              err_o <= 1'b0;
              id_q <= req_id_i;
              safe_o <= 1'b1;
              cnt <= Q_LOAD;
              state <= QUIESCE;
            end
          end
        QUIESCE:
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            design_rst_n_o[sel_id_o] <= 1'b0;
            design_rst_n_o[id_q] <= 1'b0;
            sel_id_o <= id_q;
            cnt <= R_LOAD;
            state <= HOLD_RST;
          end
        HOLD_RST:
          if (cnt != '0) cnt <= cnt - 1'b1;
          else begin
            design_rst_n_o[sel_id_o] <= 1'b1;
            safe_o <= 1'b0;
            ack_o <= !boot;
            boot <= 1'b0;
            state <= boot ? IDLE : ACK;
          end
        ACK:
          if (!req_s) begin
            ack_o <= 1'b0;
            state <= IDLE;
          end
      endcase
    end
endmodule

// File: tb/tb_design_select_ctrl.sv
// tb_design_select_ctrl: directed table-driven bench for the design select sequencer.
module tb_design_select_ctrl;
  logic clk = 1'b0, rst_n = 1'b0, req = 1'b0;
  logic [3:0] req_id = 4'd0;
  logic ack, err, busy, safe;
  logic [3:0] sel;
  logic [15:0] drst;
  int n_cmp = 0, n_bad = 0;
  typedef struct {
    logic [3:0]  id;
    logic [3:0]  sel;
    logic        err;
    logic [15:0] drst;
    int          safe_n;
  } vec_t;
  vec_t vecs[6];
  design_select_ctrl dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .req_i(req), .req_id_i(req_id),
    .ack_o(ack), .err_o(err), .busy_o(busy), .sel_id_o(sel),
    .safe_o(safe), .design_rst_n_o(drst)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_sel"}, 32'(sel), 32'd15);
    chk({tag, "_safe"}, 32'(safe), 32'd0);
    chk({tag, "_ack"}, 32'(ack), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_drst"}, 32'(drst), 32'h7fff);
  endtask
  task automatic boot_release(input string tag);
    int done_n = 0;
    rst_n = 1'b1;
    for (int n = 1; n <= 20 && done_n == 0; n++) begin
      step();
      if (drst == 16'hffff) done_n = n;
    end
    chk({tag, "_release_cycle"}, 32'(done_n), 32'd8);
    chk({tag, "_boot_busy"}, 32'(busy), 32'd0);
    chk({tag, "_boot_ack"}, 32'(ack), 32'd0);
  endtask
  task automatic run_vec(input int i);
    int safe_n = 0, got_ack = 0, idle_n = 0;
    req_id = vecs[i].id;
    req = 1'b1;
    for (int n = 1; n <= 60 && got_ack == 0; n++) begin
      step();
      if (safe) safe_n++;
      if (ack) got_ack = 1;
    end
    chk($sformatf("v%0d_ack", i), 32'(got_ack), 32'd1);
    chk($sformatf("v%0d_safe_cycles", i), 32'(safe_n), 32'(vecs[i].safe_n));
    chk($sformatf("v%0d_sel", i), 32'(sel), 32'(vecs[i].sel));
    chk($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].err));
    chk($sformatf("v%0d_drst", i), 32'(drst), 32'(vecs[i].drst));
    req = 1'b0;
    for (int n = 1; n <= 10 && idle_n == 0; n++) begin
      step();
      if (!busy && !ack) idle_n = n;
    end
    chk($sformatf("v%0d_return_idle", i), 32'(idle_n != 0), 32'd1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int first_safe = 0, first_sel = 0, drop = 0, ack_drop = 0, ack_cnt = 0;
    logic [15:0] drst_sel = '0;
    vecs[0] = '{id: 4'd5,  sel: 4'd0,  err: 1'b1, drst: 16'h7fff, safe_n: 0};
    vecs[1] = '{id: 4'd0,  sel: 4'd0,  err: 1'b0, drst: 16'h7fff, safe_n: 24};
    vecs[2] = '{id: 4'd15, sel: 4'd15, err: 1'b0, drst: 16'hfffe, safe_n: 24};
    vecs[3] = '{id: 4'd3,  sel: 4'd15, err: 1'b1, drst: 16'hfffe, safe_n: 0};
    vecs[4] = '{id: 4'd15, sel: 4'd15, err: 1'b0, drst: 16'hfffe, safe_n: 24};
    vecs[5] = '{id: 4'd0,  sel: 4'd0,  err: 1'b0, drst: 16'h7fff, safe_n: 24};
    repeat (3) step();
    chk_reset_vals("rst");
    boot_release("boot");
    // first switch 15 -> 0 with cycle-exact timing from the req_i edge
    req_id = 4'd0;
    req = 1'b1;
    for (int n = 1; n <= 40 && drop == 0; n++) begin
      step();
      if (safe && first_safe == 0) first_safe = n;
      if (sel == 4'd0 && first_sel == 0) begin
        first_sel = n;
        drst_sel = drst;
      end
      if (first_safe != 0 && !safe) begin
        drop = n;
        ack_drop = int'(ack);
      end
    end
    chk("t_safe_rise", 32'(first_safe), 32'd3);
    chk("t_sel_change", 32'(first_sel), 32'd19);
    chk("t_drst_hold", 32'(drst_sel), 32'h7ffe);
    chk("t_safe_fall", 32'(drop), 32'd27);
    chk("t_ack_with_fall", 32'(ack_drop), 32'd1);
    chk("t_drst_done", 32'(drst), 32'h7fff);
    req = 1'b0;
    repeat (2) step();
    chk("t_ack_held", 32'(ack), 32'd1);
    step();
    chk("t_ack_drop", 32'(ack), 32'd0);
    chk("t_busy_drop", 32'(busy), 32'd0);
    for (int i = 0; i < 6; i++) run_vec(i);
    // short pulse on req_i with req_id_i wandering mid-sequence
    req_id = 4'd15;
    req = 1'b1;
    for (int n = 1; n <= 45; n++) begin
      step();
      if (n == 3) req = 1'b0;
      if (n == 5) req_id = 4'd5;
      if (n == 21) req_id = 4'd0;
      if (ack) ack_cnt++;
    end
    chk("p_ack_pulse", 32'(ack_cnt), 32'd1);
    chk("p_sel", 32'(sel), 32'd15);
    chk("p_drst", 32'(drst), 32'hfffe);
    chk("p_busy", 32'(busy), 32'd0);
    chk("p_err", 32'(err), 32'd0);
    // asynchronous reset while quiescing
    req_id = 4'd0;
    req = 1'b1;
    repeat (8) step();
    chk("r_in_quiesce", 32'(safe), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("r_async");
    req = 1'b0;
    repeat (2) step();
    boot_release("r_boot");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
